// File: rtl/sram_model.sv
// Single-port synchronous SRAM model with registered read data.
// An asynchronous reset clears the output register and every stored word.
module sram_model #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] ad,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] dout_d;
  logic             in_range;

  // The extra bit keeps the comparison exact when DEPTH is a power of two.
  assign in_range = ({1'b0, ad} < (DEPTH_LOG + 1)'(DEPTH));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (cs && we && in_range) begin
      mem_d[ad] = din;
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (cs && !we) begin
      dout_d = in_range ? mem_q[ad] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_sram_model.sv
// Self-checking bench: a DEPTH=8 and a DEPTH=6 instance share one stimulus stream
// and are compared every cycle against simple array models.
module tb_sram_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        we;
  logic [2:0]  ad;
  logic [31:0] din;
  logic [31:0] dout8;
  logic [31:0] dout6;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  sram_model #(.DEPTH(8), .WIDTH(32)) dut8 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .ad(ad), .din(din), .dout(dout8)
  );

  sram_model #(.DEPTH(6), .WIDTH(32)) dut6 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .ad(ad), .din(din), .dout(dout6)
  );

  // Reference memories: plain arrays, the last read value, cleared on reset.
  logic [31:0] m8 [8];
  logic [31:0] m6 [6];
  logic [31:0] e8;
  logic [31:0] e6;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m8[i] = 32'h0;
      for (int i = 0; i < 6; i++) m6[i] = 32'h0;
      e8 = 32'h0;
      e6 = 32'h0;
    end else if (cs) begin
      if (we) begin
        m8[ad] = din;
        if (int'(ad) < 6) m6[ad] = din;
      end else begin
        e8 = m8[ad];
        e6 = (int'(ad) < 6) ? m6[ad] : 32'h0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_dout8", dout8, e8);
      chk("model_dout6", dout6, e6);
    end
  end

  task automatic cyc(input logic c, input logic w, input logic [2:0] a, input logic [31:0] d);
    cs  = c;
    we  = w;
    ad  = a;
    din = d;
    @(negedge clk);
  endtask

  logic [31:0] exp6 [6];

  initial begin
    rst_n = 1'b0;
    cs = 1'b0; we = 1'b0; ad = 3'd0; din = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_dout8", dout8, 32'h0);
    chk("reset_dout6", dout6, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Fill and readback, starting on the very first edge after reset release.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), 32'h10 + 32'(i));
    cyc(1'b0, 1'b0, 3'd0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 3'(i), 32'h0);
      chk("fill_rd8", dout8, 32'h10 + 32'(i));
      chk("fill_rd6", dout6, (i < 6) ? 32'h10 + 32'(i) : 32'h0);
    end

    // Deselect must not write.
    cyc(1'b1, 1'b1, 3'd3, 32'hAA);
    cyc(1'b0, 1'b1, 3'd3, 32'hFF);
    cyc(1'b1, 1'b0, 3'd3, 32'h0);
    chk("deselect", dout8, 32'hAA);

    // Output holds across idle and write cycles.
    cyc(1'b1, 1'b0, 3'd2, 32'h0);
    chk("hold_rd", dout8, 32'h12);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 3'd2, 32'h0);
      chk("hold_idle", dout8, 32'h12);
    end
    cyc(1'b1, 1'b1, 3'd4, 32'h77);
    chk("hold_wr", dout8, 32'h12);

    // Read-after-write on consecutive cycles.
    cyc(1'b1, 1'b1, 3'd5, 32'h55);
    cyc(1'b1, 1'b0, 3'd5, 32'h0);
    chk("raw", dout8, 32'h55);

    // Out-of-range access on the DEPTH=6 instance.
    cyc(1'b1, 1'b1, 3'd7, 32'hDEAD);
    cyc(1'b1, 1'b0, 3'd7, 32'h0);
    chk("oor_rd6", dout6, 32'h0);
    chk("oor_rd8", dout8, 32'hDEAD);
    exp6 = '{32'h10, 32'h11, 32'h12, 32'hAA, 32'h77, 32'h55};
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 3'(i), 32'h0);
      chk("oor_keep6", dout6, exp6[i]);
    end

    // Randomized mix of back-to-back reads, writes and idles.
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
    end

    // Refill, then pulse reset between edges.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 3'(i), 32'h10 + 32'(i));
    cyc(1'b1, 1'b0, 3'd6, 32'h0);
    chk("pre_reset", dout8, 32'h16);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dout8", dout8, 32'h0);
    chk("async_dout6", dout6, 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 3'(i), 32'h0);
      chk("post_reset8", dout8, 32'h0);
    end

    // Accesses while reset is held are ignored.
    cyc(1'b1, 1'b1, 3'd1, 32'h1234);
    #2 rst_n = 1'b0;
    cyc(1'b1, 1'b1, 3'd1, 32'h99);
    cyc(1'b1, 1'b0, 3'd1, 32'h0);
    chk("in_reset_rd", dout8, 32'h0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 3'd1, 32'h0);
    chk("in_reset_wr", dout8, 32'h0);

    chk_en = 1'b0;
    cyc(1'b0, 1'b0, 3'd0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_model.md
SRAM_MODEL -- requirements
Module: sram_model

Interface
REQ-001 Parameter DEPTH, default 8: number of words; SHALL be >= 2.
REQ-002 Parameter WIDTH, default 32: bits per word; SHALL be >= 1.
REQ-003 Parameter DEPTH_LOG, default $clog2(DEPTH): address width in bits.
REQ-004 Port order SHALL be clk, rst_n, cs, we, ad, din, dout.
REQ-005 clk  input  1  single clock; all sequential logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cs  input  1  chip select; no access takes place when 0.
REQ-008 we  input  1  write enable; 1 = write, 0 = read, qualified by cs.
REQ-009 ad  input  DEPTH_LOG  word address.
REQ-010 din  input  WIDTH  write data.
REQ-011 dout  output  WIDTH  registered read data.

Function
REQ-012 Storage SHALL be an array of DEPTH words, each WIDTH bits wide.
REQ-013 Write: at posedge clk with cs=1, we=1 and ad<DEPTH, mem[ad] SHALL take din.
REQ-014 A write SHALL be visible to a read issued on any later clock edge.
REQ-015 Read: at posedge clk with cs=1, we=0, dout SHALL take mem[ad] (1-cycle latency, synchronous read).
REQ-016 dout SHALL hold its previous value on write cycles and when cs=0.
REQ-017 cs=0 SHALL leave memory unchanged regardless of we, ad and din.
REQ-018 Out-of-range address (ad>=DEPTH, possible only when DEPTH is not a power of 2):
- writes SHALL be ignored;
- reads SHALL load dout with 0.
REQ-019 Back-to-back accesses on consecutive cycles SHALL be supported with no idle cycles, for any mix of reads and writes.
REQ-020 The block SHALL not drive X onto dout after reset, including when reading unwritten locations.

Reset
REQ-021 When rst_n=0, asynchronously and regardless of clk:
- dout SHALL go to 0;
- all memory words SHALL go to 0.
REQ-022 While rst_n=0, cs and we SHALL be ignored and no write SHALL take effect.
REQ-023 Reset deassertion SHALL be sampled with clk. The first access SHALL be honored on the first rising edge at which rst_n=1.
REQ-024 Reset asserted in the middle of a write or read sequence SHALL abort the sequence. Afterwards every location SHALL read 0.

Verification
REQ-025 Fill and readback (DEPTH=8, WIDTH=32):
- write 0x10+i to addresses 0..7 on 8 consecutive cycles;
- idle one cycle with cs=0;
- read addresses 0..7 on consecutive cycles;
- required: dout = 0x10+i on the edge after address i is presented (0x10..0x17).
REQ-026 Deselect:
- write 0xAA to address 3;
- drive cs=0, we=1, din=0xFF, ad=3;
- read address 3;
- required: dout = 0xAA.
REQ-027 Hold:
- read address 2 returning 0x12;
- then 3 cycles with cs=0, followed by one write cycle;
- required: dout stays 0x12 throughout.
REQ-028 Async reset:
- after the fill, pulse rst_n low between clock edges;
- required: dout = 0 immediately;
- required: subsequent reads of all addresses return 0.
REQ-029 Read-after-write:
- write 0x55 to address 5, then read address 5 on the next cycle;
- required: dout = 0x55 one edge after the read.
REQ-030 Non-power-of-2 (DEPTH=6):
- write to address 7, then read address 7;
- required: dout = 0;
- required: addresses 0..5 are unchanged.
